// File: rtl/display_scan_pkg.sv
// Shared types and register map for the multiplexed 7-segment display scanner.
// Digit nibbles are packed eight to a 32-bit word, digit i at bits [4i+3:4i].
package display_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    localparam logic [3:0] ADDR_SHADOW0 = 4'h0;
    localparam logic [3:0] ADDR_SHADOW1 = 4'h1;
    localparam logic [3:0] ADDR_SHADOW2 = 4'h2;
    localparam logic [3:0] ADDR_SHADOW3 = 4'h3;
    localparam logic [3:0] ADDR_DP      = 4'h4;
    localparam logic [3:0] ADDR_CTRL    = 4'h5;
    localparam logic [3:0] ADDR_DIV     = 4'h6;
    localparam logic [3:0] ADDR_DWELL   = 4'h7;
    localparam logic [3:0] ADDR_CMD     = 4'h8;

    localparam int unsigned CTRL_EN_BIT      = 7;
    localparam int unsigned CTRL_LZS_BIT     = 6;
    localparam int unsigned CTRL_POL_BIT     = 5;
    localparam int unsigned STAT_PENDING_BIT = 7;
    localparam int unsigned STAT_BUSY_BIT    = 6;

    function automatic logic [3:0] digit_at(input logic [31:0] digits, input logic [2:0] idx);
        return digits[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Programmable tick generator: counts 0..divider and pulses tick on the wrap cycle.
// clear holds the count at zero so the first tick after release is a full period away.
module scan_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [7:0] divider,
    output logic       tick
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        tick  = (cnt_q >= divider);
        cnt_d = (clear || tick) ? '0 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed digit scanner sharing one external BCD-to-7-segment decoder,
// with double-buffered digit store, blanking dead-time and ripple-blank chaining.
module display_scan_controller #(
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            address,
    input  logic                  data_write,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic [3:0]            dec_bcd,
    output logic                  dec_rbi,
    input  logic [6:0]            dec_seg,
    input  logic                  dec_rbo,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_en
);

    import display_scan_pkg::*;

    localparam logic [2:0] LAST_MAX = 3'(NUM_DIGITS - 1);

    scan_state_e           state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [2:0]            frame_last_q, frame_last_d;
    logic [3:0]            dwell_cnt_q, dwell_cnt_d;
    logic [31:0]           shadow_q, shadow_d;
    logic [7:0]            shadow_dp_q, shadow_dp_d;
    logic [31:0]           active_q, active_d;
    logic [7:0]            active_dp_q, active_dp_d;
    logic                  en_q, en_d;
    logic                  lzs_q, lzs_d;
    logic                  pol_q, pol_d;
    logic [2:0]            last_q, last_d;
    logic [7:0]            div_q, div_d;
    logic [3:0]            dwell_q, dwell_d;
    logic                  pending_q, pending_d;
    logic [3:0]            dec_bcd_q, dec_bcd_d;
    logic                  dec_rbi_q, dec_rbi_d;
    logic [7:0]            seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;

    logic                  tick;
    logic                  prescale_clear;
    logic                  frame_end;
    logic                  commit_wr;
    logic                  apply_commit;
    logic [NUM_DIGITS-1:0] onehot;

    assign prescale_clear = (state_q == ST_IDLE);

    scan_prescaler u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (prescale_clear),
        .divider (div_q),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= LAST_MAX;
            frame_last_q <= LAST_MAX;
            dwell_cnt_q  <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            en_q         <= 1'b0;
            lzs_q        <= 1'b0;
            pol_q        <= 1'b0;
            last_q       <= LAST_MAX;
            div_q        <= '0;
            dwell_q      <= '0;
            pending_q    <= 1'b0;
            dec_bcd_q    <= '0;
            dec_rbi_q    <= 1'b0;
            seg_out_q    <= '0;
            dig_en_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_last_q <= frame_last_d;
            dwell_cnt_q  <= dwell_cnt_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            en_q         <= en_d;
            lzs_q        <= lzs_d;
            pol_q        <= pol_d;
            last_q       <= last_d;
            div_q        <= div_d;
            dwell_q      <= dwell_d;
            pending_q    <= pending_d;
            dec_bcd_q    <= dec_bcd_d;
            dec_rbi_q    <= dec_rbi_d;
            seg_out_q    <= seg_out_d;
            dig_en_q     <= dig_en_d;
        end
    end

    // Register file; a commit copies the pre-write shadow, so a same-edge shadow write stays pending.
    always_comb begin
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        en_d         = en_q;
        lzs_d        = lzs_q;
        pol_d        = pol_q;
        last_d       = last_q;
        div_d        = div_q;
        dwell_d      = dwell_q;
        commit_wr    = data_write && (address == ADDR_CMD) && data_in[0];
        apply_commit = frame_end && (pending_q || commit_wr);
        active_d     = apply_commit ? shadow_q : active_q;
        active_dp_d  = apply_commit ? shadow_dp_q : active_dp_q;
        pending_d    = apply_commit ? 1'b0 : (commit_wr ? 1'b1 : pending_q);
        if (data_write) begin
            case (address)
                ADDR_SHADOW0, ADDR_SHADOW1, ADDR_SHADOW2, ADDR_SHADOW3:
                    shadow_d[{address[1:0], 3'b000} +: 8] = data_in;
                ADDR_DP:    shadow_dp_d = data_in;
                ADDR_CTRL: begin
                    en_d   = data_in[CTRL_EN_BIT];
                    lzs_d  = data_in[CTRL_LZS_BIT];
                    pol_d  = data_in[CTRL_POL_BIT];
                    last_d = (data_in[2:0] > LAST_MAX) ? LAST_MAX : data_in[2:0];
                end
                ADDR_DIV:   div_d   = data_in;
                ADDR_DWELL: dwell_d = data_in[3:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_last_d = frame_last_q;
        dwell_cnt_d  = dwell_cnt_q;
        frame_end    = 1'b0;
        if (!en_q) begin
            state_d = ST_IDLE;
            idx_d   = last_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_BLANK;
                    idx_d        = last_q;
                    frame_last_d = last_q;
                end
                ST_BLANK: begin
                    if (tick) begin
                        state_d     = ST_SHOW;
                        dwell_cnt_d = '0;
                    end
                end
                ST_SHOW: begin
                    if (tick) begin
                        if (dwell_cnt_q >= dwell_q) begin
                            state_d = ST_BLANK;
                            if (idx_q == 3'd0) begin
                                frame_end    = 1'b1;
                                idx_d        = last_q;
                                frame_last_d = last_q;
                            end else begin
                                idx_d = idx_q - 3'd1;
                            end
                        end else begin
                            dwell_cnt_d = dwell_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Decoder inputs load on BLANK entry using post-commit data so the decoder settles during BLANK.
    always_comb begin
        dec_bcd_d = dec_bcd_q;
        dec_rbi_d = dec_rbi_q;
        if ((state_d == ST_BLANK) && (state_q != ST_BLANK)) begin
            dec_bcd_d = digit_at(active_d, idx_d);
            if (idx_d == 3'd0) begin
                dec_rbi_d = 1'b0;
            end else if (idx_d == frame_last_d) begin
                dec_rbi_d = lzs_q;
            end else begin
                dec_rbi_d = dec_rbo;
            end
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            onehot[i] = (idx_q == 3'(i));
        end
        if (state_d == ST_SHOW) begin
            seg_out_d = {active_dp_q[idx_q], dec_seg};
            dig_en_d  = onehot ^ {NUM_DIGITS{pol_q}};
        end else begin
            seg_out_d = '0;
            dig_en_d  = {NUM_DIGITS{pol_q}};
        end
    end

    always_comb begin
        case (address)
            ADDR_SHADOW0, ADDR_SHADOW1, ADDR_SHADOW2, ADDR_SHADOW3:
                data_out = shadow_q[{address[1:0], 3'b000} +: 8];
            ADDR_DP:    data_out = shadow_dp_q;
            ADDR_CTRL:  data_out = {en_q, lzs_q, pol_q, 2'b00, last_q};
            ADDR_DIV:   data_out = div_q;
            ADDR_DWELL: data_out = {4'b0000, dwell_q};
            ADDR_CMD:   data_out = {pending_q, (state_q != ST_IDLE), 3'b000, idx_q};
            default:    data_out = '1;
        endcase
    end

    assign dec_bcd = dec_bcd_q;
    assign dec_rbi = dec_rbi_q;
    assign seg_out = seg_out_q;
    assign dig_en  = dig_en_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: slot-timing reference model compared every cycle,
// directed scenarios with literal expectations, then randomized register traffic.
module tb_display_scan_controller;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   address;
    logic         data_write;
    logic [7:0]   data_in;
    logic [7:0]   data_out;
    logic [3:0]   dec_bcd;
    logic         dec_rbi;
    logic [6:0]   dec_seg;
    logic         dec_rbo;
    logic [7:0]   seg_out;
    logic [N-1:0] dig_en;
    logic [7:0]   dec_resp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    display_scan_controller #(.NUM_DIGITS(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .dec_bcd    (dec_bcd),
        .dec_rbi    (dec_rbi),
        .dec_seg    (dec_seg),
        .dec_rbo    (dec_rbo),
        .seg_out    (seg_out),
        .dig_en     (dig_en)
    );

    // External decoder: returns {rbo, g..a}; a zero with rbi set is blanked and propagates rbo.
    function automatic logic [7:0] dec7(input logic [3:0] b, input logic rbi);
        logic [6:0] s;
        case (b)
            4'd0: s = 7'h3F; 4'd1: s = 7'h06; 4'd2: s = 7'h5B; 4'd3: s = 7'h4F;
            4'd4: s = 7'h66; 4'd5: s = 7'h6D; 4'd6: s = 7'h7D; 4'd7: s = 7'h07;
            4'd8: s = 7'h7F; 4'd9: s = 7'h6F;
            default: s = 7'h00;
        endcase
        if (rbi && (b == 4'd0)) return 8'h80;
        return {1'b0, s};
    endfunction

    assign dec_resp = dec7(dec_bcd, dec_rbi);
    assign dec_seg  = dec_resp[6:0];
    assign dec_rbo  = dec_resp[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [3:0]   m_shd [8];
    logic [3:0]   m_act [8];
    logic [7:0]   m_shdp, m_actdp;
    logic         m_en, m_lzs, m_pol, m_pending, m_busy;
    int           m_last, m_div, m_dwell, m_t, m_idx, m_flast;
    logic [3:0]   m_bcd;
    logic         m_rbi;
    logic [7:0]   m_seg;
    logic [N-1:0] m_dig;

    task model_step;
        logic cw, fe, newslot, chain, show;
        logic [7:0] d;
        logic [N-1:0] oh, pf;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin m_shd[i] = 4'h0; m_act[i] = 4'h0; end
            m_shdp = 8'h00; m_actdp = 8'h00; m_en = 1'b0; m_lzs = 1'b0; m_pol = 1'b0;
            m_last = N - 1; m_div = 0; m_dwell = 0; m_pending = 1'b0; m_busy = 1'b0;
            m_t = 0; m_idx = N - 1; m_flast = N - 1; m_bcd = 4'h0; m_rbi = 1'b0;
            m_seg = 8'h00; m_dig = '0;
        end else begin
            cw = data_write && (address == 4'h8) && data_in[0];
            fe = 1'b0; newslot = 1'b0; chain = 1'b0;
            if (!m_en) begin
                m_busy = 1'b0; m_idx = m_last;
            end else if (!m_busy) begin
                m_busy = 1'b1; m_t = 0; m_idx = m_last; m_flast = m_last; newslot = 1'b1;
            end else begin
                m_t++;
                if (m_t == (m_dwell + 2) * (m_div + 1)) begin
                    m_t = 0; newslot = 1'b1;
                    d = dec7(m_bcd, m_rbi);
                    chain = d[7];
                    if (m_idx == 0) begin
                        fe = 1'b1; m_idx = m_last; m_flast = m_last;
                    end else begin
                        m_idx--;
                    end
                end
            end
            if (fe && (m_pending || cw)) begin
                for (int i = 0; i < 8; i++) m_act[i] = m_shd[i];
                m_actdp = m_shdp; m_pending = 1'b0;
            end else if (cw) begin
                m_pending = 1'b1;
            end
            if (newslot) begin
                m_bcd = m_act[m_idx];
                m_rbi = (m_idx == 0) ? 1'b0 : ((m_idx == m_flast) ? m_lzs : chain);
            end
            show = m_busy && (m_t >= m_div + 1);
            pf = m_pol ? '1 : '0;
            oh = '0; oh[m_idx] = 1'b1;
            d = dec7(m_bcd, m_rbi);
            m_seg = show ? {m_actdp[m_idx], d[6:0]} : 8'h00;
            m_dig = show ? (oh ^ pf) : pf;
            if (data_write) begin
                case (address)
                    4'h0, 4'h1, 4'h2, 4'h3: begin
                        m_shd[2 * address]     = data_in[3:0];
                        m_shd[2 * address + 1] = data_in[7:4];
                    end
                    4'h4: m_shdp = data_in;
                    4'h5: begin
                        m_en = data_in[7]; m_lzs = data_in[6]; m_pol = data_in[5];
                        m_last = (int'(data_in[2:0]) > N - 1) ? N - 1 : int'(data_in[2:0]);
                    end
                    4'h6: m_div = int'(data_in);
                    4'h7: m_dwell = int'(data_in[3:0]);
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] a);
        case (a)
            4'h0, 4'h1, 4'h2, 4'h3: return {m_shd[2 * a + 1], m_shd[2 * a]};
            4'h4: return m_shdp;
            4'h5: return {m_en, m_lzs, m_pol, 2'b00, 3'(m_last)};
            4'h6: return 8'(m_div);
            4'h7: return {4'h0, 4'(m_dwell)};
            4'h8: return {m_pending, m_busy, 3'b000, 3'(m_idx)};
            default: return 8'hFF;
        endcase
    endfunction

    // Single compare process: advance the model at each edge, compare just after it.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("dec_bcd", 32'(dec_bcd), 32'(m_bcd));
            check("dec_rbi", 32'(dec_rbi), 32'(m_rbi));
            check("seg_out", 32'(seg_out), 32'(m_seg));
            check("dig_en", 32'(dig_en), 32'(m_dig));
            check("data_out", 32'(data_out), 32'(m_read(address)));
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; data_in = d; data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0; address = 4'h8;
    endtask

    task automatic wait_commit(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (!data_out[7]) begin ok = 1'b1; break; end
        end
        check("commit_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        bit ok;
        int show_len, blank_len;
        rst_n = 1'b0; address = 4'h8; data_in = 8'h00; data_write = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        address = 4'h5; #1; check("rst_ctrl", 32'(data_out), 32'h07);
        address = 4'h9; #1; check("unmapped", 32'(data_out), 32'hFF);
        address = 4'h8; #1; check("rst_status", 32'(data_out), 32'h07);

        // Counting frame
        wr(4'h0, 8'h21); wr(4'h1, 8'h43); wr(4'h2, 8'h65); wr(4'h3, 8'h87);
        wr(4'h8, 8'h01); wr(4'h6, 8'h00); wr(4'h7, 8'h00);
        #1; check("pending_idle", 32'(data_out), 32'h87);
        wr(4'h5, 8'h87);
        wait_commit(ok);
        check("count_bcd7", 32'(dec_bcd), 32'd8);
        @(posedge clk); #2;
        check("count_seg7", 32'(seg_out), 32'h7F);
        check("count_dig7", 32'(dig_en), 32'h80);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #2;
            check("count_bcd", 32'(dec_bcd), 32'(8 - k));
            @(posedge clk); #2;
        end

        // Leading-zero suppression: digits 7..0 = 0,0,0,0,0,3,0,5
        wr(4'h5, 8'h07);
        wr(4'h0, 8'h05); wr(4'h1, 8'h03); wr(4'h2, 8'h00); wr(4'h3, 8'h00); wr(4'h4, 8'h00);
        wr(4'h8, 8'h01); wr(4'h5, 8'hC7);
        wait_commit(ok);
        check("lzs_rbi7", 32'(dec_rbi), 32'd1);
        @(posedge clk); #2;
        check("lzs_seg7", 32'(seg_out), 32'h00);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #2;
            if (7 - k >= 3) check("lzs_rbi_hi", 32'(dec_rbi), 32'd1);
            if (7 - k <= 1) check("lzs_rbi_lo", 32'(dec_rbi), 32'd0);
            @(posedge clk); #2;
        end

        // Prescaler and dwell
        wr(4'h5, 8'h07); wr(4'h6, 8'h03); wr(4'h7, 8'h02); wr(4'h5, 8'h87);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (dig_en != '0) begin ok = 1'b1; break; end
        end
        check("show_timeout", 32'(ok), 32'd1);
        show_len = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (dig_en != '0) show_len++; else break;
        end
        blank_len = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (dig_en == '0) blank_len++; else break;
        end
        check("blank_len", 32'(blank_len), 32'd4);
        check("slot_len", 32'(show_len + blank_len), 32'd16);

        // Polarity and disable mid-SHOW
        wr(4'h5, 8'hA7);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (dig_en == 8'h7F) begin ok = 1'b1; break; end
        end
        check("pol_timeout", 32'(ok), 32'd1);
        wr(4'h8, 8'h01);
        wr(4'h5, 8'h27);
        @(posedge clk); #2;
        check("dis_dig", 32'(dig_en), 32'hFF);
        check("dis_seg", 32'(seg_out), 32'h00);
        check("dis_status", 32'(data_out), 32'h87);

        // Reset mid-SHOW
        wr(4'h5, 8'h87);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (dig_en != '0) begin ok = 1'b1; break; end
        end
        check("rst_show_timeout", 32'(ok), 32'd1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        check("mrst_dig", 32'(dig_en), 32'h00);
        check("mrst_seg", 32'(seg_out), 32'h00);
        check("mrst_bcd", 32'(dec_bcd), 32'h0);
        check("mrst_rbi", 32'(dec_rbi), 32'h0);
        check("mrst_status", 32'(data_out), 32'h07);
        address = 4'h5; #1; check("mrst_ctrl", 32'(data_out), 32'h07);
        address = 4'h3; #1; check("mrst_shadow", 32'(data_out), 32'h00);

        // Randomized traffic; timing registers change only while disabled
        for (int blk = 0; blk < 10; blk++) begin
            wr(4'h5, {3'b000, 2'b00, 3'($urandom_range(0, 7))});
            wr(4'h6, 8'($urandom_range(0, 3)));
            wr(4'h7, 8'($urandom_range(0, 3)));
            wr(4'h5, {1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00,
                      3'($urandom_range(0, 7))});
            for (int op = 0; op < 200; op++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: wr(4'($urandom_range(0, 3)), 8'($urandom));
                    4: wr(4'h4, 8'($urandom));
                    5: wr(4'h8, 8'($urandom_range(0, 1)));
                    6: wr(4'h5, {1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                 2'b00, 3'($urandom_range(0, 7))});
                    default: begin
                        @(negedge clk);
                        address = 4'($urandom_range(0, 15));
                    end
                endcase
            end
        end

        repeat (2) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
